sdram_rd_buf_ctrl: RTL

- Read-side buffer controller that sits directly downstream of the SDRAM read engine and also drives that engine's request inputs.
- Holds a synchronous FIFO that captures the burst words the read engine emits.
- Issues burst read requests (rd_en/rd_addr/rd_burst_len) whenever the FIFO has room for a full burst, walking a circular SDRAM address window.
- Presents a simple pop interface to the user/display side.

---
 rtl/sdram_rd_buf_ctrl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_rd_buf_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_rd_buf_ctrl
//
// Read-side buffer controller for the SDRAM read engine. Issues one burst read
// request at a time whenever the local FIFO has room for a full burst, walking
// a circular word-address window [ADDR_MIN, ADDR_MAX]. Captures the returned
// burst words in a synchronous FIFO and presents a registered pop interface.
//
// Optional feature (macro RD_WORD_CNT_EN): counts words written during each
// burst and flags burst_err (sticky) when the count at rd_end differs from
// BURST_LEN. With the macro undefined, burst_err is tied low.
//
// Ports:
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   init_end           SDRAM initialisation complete
//   buf_en             prefetch enable
//   addr_clear         pulse: restart address at ADDR_MIN
//   rd_en/rd_addr      burst read request and start address to the engine
//   rd_burst_len       constant BURST_LEN
//   rd_end             burst completion pulse from the engine
//   rd_fifo_wr_en/data word write from the engine
//   user_rd_en         pop request
//   user_rd_data/valid popped word, valid one cycle after an accepted pop
//   fifo_level         words held
//   overflow           sticky: word dropped on a full FIFO
//   burst_err          sticky: burst word-count error (optional feature)
// -----------------------------------------------------------------------------
module sdram_rd_buf_ctrl #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned BURST_LEN = 256,
  parameter logic [23:0] ADDR_MIN  = 24'h000000,
  parameter logic [23:0] ADDR_MAX  = 24'h0003FF
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      init_end,
  input  logic                      buf_en,
  input  logic                      addr_clear,
  output logic                      rd_en,
  output logic [23:0]               rd_addr,
  output logic [9:0]                rd_burst_len,
  input  logic                      rd_end,
  input  logic                      rd_fifo_wr_en,
  input  logic [DATA_W-1:0]         rd_fifo_wr_data,
  input  logic                      user_rd_en,
  output logic [DATA_W-1:0]         user_rd_data,
  output logic                      user_rd_valid,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow,
  output logic                      burst_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] user_rd_data_q, user_rd_data_d;
  logic              user_rd_valid_q, user_rd_valid_d;
  logic              overflow_q, overflow_d;

  logic full_c, empty_c, push_c, pop_c;

  assign full_c  = (level_q == LW'(DEPTH));
  assign empty_c = (level_q == '0);
  assign push_c  = rd_fifo_wr_en & ~full_c;
  assign pop_c   = user_rd_en & ~empty_c;

  // FIFO next-state: pointers wrap modulo DEPTH (power of two)
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    user_rd_data_d  = user_rd_data_q;
    user_rd_valid_d = 1'b0;
    overflow_d      = overflow_q;

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_fifo_wr_en && full_c) begin
      overflow_d = 1'b1;
    end
    if (pop_c) begin
      rd_ptr_d        = rd_ptr_q + AW'(1);
      user_rd_data_d  = mem_q[rd_ptr_q];
      user_rd_valid_d = 1'b1;
    end

    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage array carries no reset; occupancy is tracked by level_q
  always_ff @(posedge sys_clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= rd_fifo_wr_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      user_rd_data_q  <= '0;
      user_rd_valid_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      user_rd_data_q  <= user_rd_data_d;
      user_rd_valid_q <= user_rd_valid_d;
      overflow_q      <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM and address walker
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic          rd_en_q, rd_en_d;
  logic [23:0]   rd_addr_q, rd_addr_d;
  logic          clear_pend_q, clear_pend_d;
  logic          room_c, start_c;
  logic [24:0]   addr_sum_c;
  logic [23:0]   addr_adv_c;

  // Room for a whole burst; level never exceeds DEPTH so no underflow
  assign room_c  = ((32'(DEPTH) - 32'(level_q)) >= 32'(BURST_LEN));
  assign start_c = init_end & buf_en & room_c;

  // 25-bit sum so the wrap compare sees any carry out of bit 23
  assign addr_sum_c = {1'b0, rd_addr_q} + 25'(BURST_LEN);
  assign addr_adv_c = (addr_sum_c > {1'b0, ADDR_MAX}) ? ADDR_MIN : addr_sum_c[23:0];

  always_comb begin
    state_d      = state_q;
    rd_en_d      = rd_en_q;
    rd_addr_d    = rd_addr_q;
    clear_pend_d = clear_pend_q;

    case (state_q)
      ST_IDLE: begin
        rd_en_d = 1'b0;
        if (addr_clear) begin
          rd_addr_d = ADDR_MIN;
        end
        if (start_c) begin
          state_d = ST_BUSY;
          rd_en_d = 1'b1;
        end
      end
      ST_BUSY: begin
        rd_en_d = 1'b1;
        if (rd_end) begin
          state_d      = ST_IDLE;
          rd_en_d      = 1'b0;
          clear_pend_d = 1'b0;
          // A clear seen during the burst replaces the normal advance
          rd_addr_d    = (clear_pend_q || addr_clear) ? ADDR_MIN : addr_adv_c;
        end else if (addr_clear) begin
          clear_pend_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rd_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= ADDR_MIN;
      clear_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      clear_pend_q <= clear_pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional burst word counter
  // ---------------------------------------------------------------------------
`ifdef RD_WORD_CNT_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic          burst_err_q, burst_err_d;

  // A word arriving on the rd_end cycle still counts toward this burst
  always_comb begin
    cnt_d       = '0;
    burst_err_d = burst_err_q;
    if (state_q == ST_BUSY) begin
      cnt_d = cnt_q + CW'(rd_fifo_wr_en);
      if (rd_end) begin
        if (cnt_d != CW'(BURST_LEN)) begin
          burst_err_d = 1'b1;
        end
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q       <= '0;
      burst_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      burst_err_q <= burst_err_d;
    end
  end

  assign burst_err = burst_err_q;
`else
  assign burst_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign rd_burst_len  = 10'(BURST_LEN);
  assign user_rd_data  = user_rd_data_q;
  assign user_rd_valid = user_rd_valid_q;
  assign fifo_level    = level_q;
  assign overflow      = overflow_q;

endmodule
